// File: rtl/seq_pkg.sv
// ============================================================================
// Module      : seq_pkg
// Description : Shared state encoding and the 0,0,1 sync pattern for the
//               sync-framed serial transmitter and its 001 detector.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SYNC0 = 3'd1,
        ST_SYNC1 = 3'd2,
        ST_SYNC2 = 3'd3,
        ST_DATA  = 3'd4,
        ST_PAR   = 3'd5,
        ST_DONE  = 3'd6
    } seq_state_t;

    // Sent MSB first: SYNC0 carries bit 2, SYNC2 carries bit 0.
    localparam logic [2:0] c_SYNC_PATTERN = 3'b001;

endpackage

`default_nettype wire

// File: rtl/seq_tx_shreg.sv
// ============================================================================
// Module      : seq_tx_shreg
// Description : Parallel-load, MSB-first shift register; load wins over shift.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module seq_tx_shreg #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             shift,
    input  logic [WIDTH-1:0] load_data,
    output logic             msb
);

    logic [WIDTH-1:0] r_data;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_data <= '0;
        end else if (load) begin
            r_data <= load_data;
        end else if (shift) begin
            r_data <= r_data << 1;
        end
    end

    assign msb = r_data[WIDTH-1];

endmodule

`default_nettype wire

// File: rtl/seq_tx_001.sv
// ============================================================================
// Module      : seq_tx_001
// Description : Moore FSM serialiser: sync 0,0,1 then DATA_W payload bits
//               MSB first, optional even-parity bit (SEQ_TX_PARITY_EN).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module seq_tx_001
    import seq_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              tx,
    output logic              busy,
    output logic              done
);

    localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [CNT_W-1:0] c_CNT_LAST = CNT_W'(DATA_W - 1);

    seq_state_t       r_state;
    seq_state_t       w_state_next;
    logic [CNT_W-1:0] r_cnt;
    logic             w_accept;
    logic             w_shift;
    logic             w_shreg_msb;

    assign w_accept = in_valid && in_ready;
    assign w_shift  = (r_state == ST_DATA);

    seq_tx_shreg #(
        .WIDTH (DATA_W)
    ) u_shreg (
        .clk       (clk),
        .reset     (reset),
        .load      (w_accept),
        .shift     (w_shift),
        .load_data (in_data),
        .msb       (w_shreg_msb)
    );

`ifdef SEQ_TX_PARITY_EN
    // Parity is captured at accept because the shift register is consumed.
    logic r_parity;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_parity <= 1'b0;
        end else if (w_accept) begin
            r_parity <= ^in_data;
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_next;
            if (r_state == ST_DATA && r_cnt != c_CNT_LAST) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end else begin
                r_cnt <= '0;
            end
        end
    end

    always_comb begin
        w_state_next = r_state;
        tx           = 1'b1;
        busy         = 1'b1;
        in_ready     = 1'b0;
        done         = 1'b0;
        case (r_state)
            ST_IDLE: begin
                busy     = 1'b0;
                in_ready = 1'b1;
                if (in_valid) begin
                    w_state_next = ST_SYNC0;
                end
            end
            ST_SYNC0: begin
                tx           = c_SYNC_PATTERN[2];
                w_state_next = ST_SYNC1;
            end
            ST_SYNC1: begin
                tx           = c_SYNC_PATTERN[1];
                w_state_next = ST_SYNC2;
            end
            ST_SYNC2: begin
                tx           = c_SYNC_PATTERN[0];
                w_state_next = ST_DATA;
            end
            ST_DATA: begin
                tx = w_shreg_msb;
                if (r_cnt == c_CNT_LAST) begin
`ifdef SEQ_TX_PARITY_EN
                    w_state_next = ST_PAR;
`else
                    w_state_next = ST_DONE;
`endif
                end
            end
`ifdef SEQ_TX_PARITY_EN
            ST_PAR: begin
                tx           = r_parity;
                w_state_next = ST_DONE;
            end
`endif
            ST_DONE: begin
                done         = 1'b1;
                w_state_next = ST_IDLE;
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

endmodule

`default_nettype wire

// File: doc/seq_tx_001.md
SEQ_TX_001 -- requirements
Module: seq_tx_001

Interface
REQ-001 The block SHALL have parameter DATA_W, default 8, payload bits per frame (legal range 1..16).
REQ-002 clk  input  1  clock; all logic SHALL be on its rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 in_valid  input  1  payload offered.
REQ-005 in_data  input  DATA_W  payload, sampled on accept.
REQ-006 in_ready  output  1  block can accept a payload.
REQ-007 tx  output  1  serial line, one bit per clk, registered.
REQ-008 busy  output  1  frame in progress.
REQ-009 done  output  1  one-cycle pulse at end of frame.

Function
REQ-010 The block SHALL be a Moore FSM; tx, busy, in_ready and done SHALL depend only on registered state.
REQ-011 The FSM SHALL have states IDLE, SYNC0, SYNC1, SYNC2, DATA, PAR (PAR only with the macro) and DONE.
REQ-012 In IDLE: tx=1, in_ready=1, busy=0, done=0.
REQ-013 Accept SHALL occur on an edge with in_valid=1 and in_ready=1; in_data SHALL be latched into a shift register at that edge.
REQ-014 After accept at edge k, the FSM SHALL transition IDLE->SYNC0.
REQ-015 SYNC0 SHALL drive tx=0 in the cycle after edge k, SYNC1 tx=0 in the next cycle, and SYNC2 tx=1 in the cycle after that (sync pattern 0,0,1).
REQ-016 DATA SHALL last DATA_W cycles and drive tx from the shift register, MSB first.
REQ-017 A bit counter SHALL count 0..DATA_W-1; DATA SHALL exit when the counter equals DATA_W-1.
REQ-018 DONE SHALL last one cycle with tx=1 and done=1, then return to IDLE.
REQ-019 busy SHALL be 1 in every state except IDLE; in_ready SHALL be 0 in every state except IDLE.
REQ-020 The minimum frame spacing SHALL be 3+DATA_W(+1 with parity)+1 (DONE)+1 (IDLE) cycles; the block SHALL NOT support back-to-back accepts.
REQ-021 in_valid and in_data changes while busy=1 SHALL be ignored and SHALL NOT alter the frame in flight.
REQ-022 Unreachable state encodings SHALL transition to IDLE with tx=1.

Reset
REQ-023 When reset=1 at an edge, the state SHALL become IDLE, tx=1, busy=0, done=0, in_ready=1, and the counter and shift register SHALL clear to 0.
REQ-024 Reset asserted mid-frame SHALL abort the frame immediately, with no done pulse; in_valid high during reset SHALL NOT be accepted.

Configuration
REQ-025 With macro SEQ_TX_PARITY_EN defined, PAR SHALL follow DATA for one cycle and drive even parity (XOR of the DATA_W payload bits); DONE SHALL follow PAR.
REQ-026 Without SEQ_TX_PARITY_EN, the PAR state and parity logic SHALL be absent and DATA SHALL go directly to DONE.

Structure
REQ-027 Package seq_pkg SHALL hold the state encoding and the SYNC pattern constant (3'b001), shared with the 001 detector.
REQ-028 Sub-module seq_tx_shreg SHALL be the parallel-load, MSB-first shift register with a load/shift enable; the FSM and counter SHALL stay in seq_tx_001.

Verification
REQ-029 Reset, then DATA_W=8, in_data=8'hA5, in_valid pulsed at edge k (no parity) -> tx over the next cycles = 0,0,1,1,0,1,0,0,1,0,1; done=1 in the following cycle; in_ready=1 one cycle later.
REQ-030 With SEQ_TX_PARITY_EN, in_data=8'h07 -> 0,0,1,0,0,0,0,0,1,1,1 then parity 1; done follows parity.
REQ-031 in_valid held high continuously with data 8'h00 then 8'hFF -> two frames, each starting only after IDLE, gap exactly as in REQ-020; the second frame carries 8'hFF.
REQ-032 reset asserted during the 4th DATA bit -> next cycle tx=1, busy=0, no done pulse; a new frame is accepted normally afterwards.
REQ-033 Loop tx into the existing 001 Moore detector over 200 random frames -> detector fires in the first cycle after every SYNC2 bit; fires elsewhere only where the payload itself contains 001; no false loss of sync.
REQ-034 in_data changed while busy=1 -> transmitted payload equals the value latched at accept.
